// File: rtl/axi4_wr_trk_pkg.sv
// Shared types for the AXI4 write-response tracker.
// Entry widths are fixed here and sized to the default port widths.
package axi4_wr_trk_pkg;

  localparam int TRK_ID_W  = 4;
  localparam int TRK_LEN_W = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [TRK_ID_W-1:0]  id;
    logic [TRK_LEN_W-1:0] len;
  } trk_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } flush_st_e;

  function automatic logic resp_is_err(input resp_e r);
    return (r == SLVERR) || (r == DECERR);
  endfunction

endpackage

// File: rtl/axi4_wr_trk_fifo.sv
// First-word-fall-through FIFO of expected write bursts.
// The caller gates push on full and pop on empty.
module axi4_wr_trk_fifo
  import axi4_wr_trk_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  trk_entry_t                 din,
  output trk_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  trk_entry_t     mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/axi4_wr_resp_tracker.sv
// Tracks outstanding AXI4 write bursts, checks B responses,
// throttles AW issue and signals flush completion.
module axi4_wr_resp_tracker
  import axi4_wr_trk_pkg::*;
#(
  parameter int IDSIZE = 4,
  parameter int LSIZE  = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic                       axi_awvalid,
  input  logic                       axi_awready,
  input  logic [IDSIZE-1:0]          axi_awid,
  input  logic [LSIZE-1:0]           axi_awlen,
  input  logic                       axi_bvalid,
  output logic                       axi_bready,
  input  logic [IDSIZE-1:0]          axi_bid,
  input  logic [1:0]                 axi_bresp,
  output logic                       aw_hold,
  input  logic                       flush,
  output logic                       flush_done,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_resp,
  output logic                       err_id,
  output logic                       err_unexp,
  output logic                       err_ovf,
  input  logic                       clr_err,
  output logic [CNT_W-1:0]           burst_cnt,
  output logic [CNT_W-1:0]           beat_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic          aw_hs;
  logic          b_hs;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          bad_resp;
  logic          id_miss;
  trk_entry_t    din;
  trk_entry_t    head;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  flush_st_e     state;
  flush_st_e     state_nxt;

  assign aw_hs    = axi_awvalid & axi_awready;
  assign b_hs     = axi_bvalid & axi_bready;
  assign push     = aw_hs & ~full;
  assign pop      = b_hs & ~empty;
  assign bad_resp = b_hs & resp_is_err(resp_e'(axi_bresp));
  assign id_miss  = pop & (head.id != TRK_ID_W'(axi_bid));
  assign din      = '{id:  TRK_ID_W'(axi_awid),
                      len: TRK_LEN_W'(axi_awlen)};
  assign cnt_nxt  = cnt + CW'(push) - CW'(pop);

  axi4_wr_trk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  assign outstanding = cnt;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      axi_bready <= 1'b0;
      aw_hold    <= 1'b0;
    end else begin
      axi_bready <= 1'b1;
      aw_hold    <= (cnt_nxt == CW'(DEPTH));
    end
  end

  // clear wins over a same-cycle set
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      err_resp  <= 1'b0;
      err_id    <= 1'b0;
      err_unexp <= 1'b0;
      err_ovf   <= 1'b0;
    end else if (clr_err) begin
      err_resp  <= 1'b0;
      err_id    <= 1'b0;
      err_unexp <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_resp  <= err_resp | bad_resp;
      err_id    <= err_id | id_miss;
      err_unexp <= err_unexp | (b_hs & empty);
      err_ovf   <= err_ovf | (aw_hs & full);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (pop) begin
        burst_cnt <= burst_cnt + 1'b1;
        beat_cnt  <= beat_cnt + CNT_W'(head.len) + CNT_W'(1);
      end
      if (bad_resp) err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (flush) state_nxt = WAIT;
      WAIT:    if (cnt == '0 && !push) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flush_done = (state == DONE);
  end

endmodule
